alien_formation_mover: RTL and testbench

Downstream companion to the zig-zag alien direction FSM. It consumes the FSM's 2-bit Motion pulse and updates the alien formation origin (form_x, form_y). It feeds back canLeft/canRight from screen bounds and the surviving columns, and generates the periodic move_enable tick that drives the FSM's enable. It also latches when the formation reaches the player line.

---
 rtl/alien_formation_mover_pkg.sv | 24 ++
 rtl/alien_tick_gen.sv | 71 +++++++
 rtl/alien_formation_mover.sv | 132 +++++++++++++
 tb/tb_alien_formation_mover.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_formation_mover_pkg.sv
// Shared definitions for the alien formation mover and the direction FSM.
// Motion encodings, screen bounds and datapath widths live here.
package alien_formation_mover_pkg;

    // One-cycle motion pulse emitted by the zig-zag direction FSM
    typedef enum logic [1:0] {
        NO_MOTION = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2,
        DOWN      = 2'd3
    } motion_e;

    // Playfield bounds in pixels (X_MAX is an exclusive edge)
    localparam int X_MIN   = 8;
    localparam int X_MAX   = 632;
    localparam int Y_LIMIT = 440;

    // Datapath widths
    localparam int FORM_X_W = 10;
    localparam int FORM_Y_W = 9;
    localparam int CALC_W   = 11;
    localparam int CNT_W    = 24;

endpackage

// File: rtl/alien_tick_gen.sv
// Periodic move_enable generator for the alien formation.
// Build option: ALIEN_SPEEDUP_EN shortens the period as columns die.
module alien_tick_gen
    import alien_formation_mover_pkg::*;
#(
    parameter int COLS = 8,
`ifdef ALIEN_SPEEDUP_EN
    parameter int MIN_PERIOD  = 200000,
    parameter int PERIOD_STEP = 225000
`else
    parameter int BASE_PERIOD = 2000000
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            frozen,
    input  logic [COLS-1:0] alive_cols,
    output logic            move_enable
);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             active;

`ifdef ALIEN_SPEEDUP_EN
    logic [CNT_W-1:0] alive_n;

    // Period grows with the number of surviving columns
    always_comb begin
        alive_n = '0;
        for (int c = 0; c < COLS; c++) begin
            alive_n = alive_n + CNT_W'(alive_cols[c]);
        end
        period = CNT_W'(MIN_PERIOD) + alive_n * CNT_W'(PERIOD_STEP);
    end
`else
    assign period = CNT_W'(BASE_PERIOD);
`endif

    assign active = run && (|alive_cols) && !frozen;

    // Count active cycles; >= lets a shrinking period fire at once instead of wrapping
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (active) begin
            if (cnt_q >= period - CNT_W'(1)) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign move_enable = tick_q;

endmodule

// File: rtl/alien_formation_mover.sv
// Alien formation origin tracker: applies Motion pulses, reports whether a
// further LEFT/RIGHT step stays on screen, and latches arrival at the bottom.
// Build option: ALIEN_SPEEDUP_EN (period scales with surviving columns).
module alien_formation_mover
    import alien_formation_mover_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    parameter int COL_PITCH = 32,
    parameter int ROW_PITCH = 24,
    parameter int ALIEN_W   = 24,
    parameter int X_INIT    = 64,
    parameter int Y_INIT    = 48,
    parameter int STEP_X    = 4,
    parameter int STEP_Y    = 8,
`ifdef ALIEN_SPEEDUP_EN
    parameter int MIN_PERIOD  = 200000,
    parameter int PERIOD_STEP = 225000
`else
    parameter int BASE_PERIOD = 2000000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [1:0]          Motion,
    input  logic [COLS-1:0]     alive_cols,
    output logic                move_enable,
    output logic                canLeft,
    output logic                canRight,
    output logic [FORM_X_W-1:0] form_x,
    output logic [FORM_Y_W-1:0] form_y,
    output logic                reached_bottom
);

    logic [FORM_X_W-1:0] form_x_q, form_x_d;
    logic [FORM_Y_W-1:0] form_y_q, form_y_d;
    logic                bottom_q, bottom_d;
    logic                can_left_q, can_left_d;
    logic                can_right_q, can_right_d;
    logic [CALC_W-1:0]   lo_idx, hi_idx;
    logic [CALC_W-1:0]   left_px, right_px, down_y;
    logic                any_alive;

    assign any_alive = |alive_cols;

    alien_tick_gen #(
        .COLS        (COLS),
`ifdef ALIEN_SPEEDUP_EN
        .MIN_PERIOD  (MIN_PERIOD),
        .PERIOD_STEP (PERIOD_STEP)
`else
        .BASE_PERIOD (BASE_PERIOD)
`endif
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .frozen      (bottom_q),
        .alive_cols  (alive_cols),
        .move_enable (move_enable)
    );

    // Leftmost and rightmost surviving column indices
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (alive_cols[c]) lo_idx = CALC_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (alive_cols[c]) hi_idx = CALC_W'(c);
        end
    end

    // Bounds check on the live formation edges; only additions, so no underflow
    always_comb begin
        left_px     = CALC_W'(form_x_q) + lo_idx * CALC_W'(COL_PITCH);
        right_px    = CALC_W'(form_x_q) + hi_idx * CALC_W'(COL_PITCH) + CALC_W'(ALIEN_W);
        can_left_d  = any_alive && (left_px >= CALC_W'(X_MIN + STEP_X));
        can_right_d = any_alive && (right_px + CALC_W'(STEP_X) <= CALC_W'(X_MAX));
    end

    // Apply the motion pulse; out-of-bounds steps are dropped, never wrapped
    always_comb begin
        form_x_d = form_x_q;
        form_y_d = form_y_q;
        bottom_d = bottom_q;
        down_y   = CALC_W'(form_y_q) + CALC_W'(STEP_Y);
        if (any_alive && !bottom_q) begin
            case (motion_e'(Motion))
                LEFT: begin
                    if (can_left_q && (form_x_q >= FORM_X_W'(STEP_X)))
                        form_x_d = form_x_q - FORM_X_W'(STEP_X);
                end
                RIGHT: begin
                    if (can_right_q) form_x_d = form_x_q + FORM_X_W'(STEP_X);
                end
                DOWN: begin
                    form_y_d = down_y[FORM_Y_W-1:0];
                    if (down_y + CALC_W'((ROWS - 1) * ROW_PITCH + ALIEN_W) >= CALC_W'(Y_LIMIT))
                        bottom_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Position, bounds flags and sticky bottom flag
    always_ff @(posedge clk) begin
        if (reset) begin
            form_x_q    <= FORM_X_W'(X_INIT);
            form_y_q    <= FORM_Y_W'(Y_INIT);
            bottom_q    <= 1'b0;
            can_left_q  <= 1'b0;
            can_right_q <= 1'b0;
        end else begin
            form_x_q    <= form_x_d;
            form_y_q    <= form_y_d;
            bottom_q    <= bottom_d;
            can_left_q  <= can_left_d;
            can_right_q <= can_right_d;
        end
    end

    assign form_x         = form_x_q;
    assign form_y         = form_y_q;
    assign reached_bottom = bottom_q;
    assign canLeft        = can_left_q;
    assign canRight       = can_right_q;

endmodule

// File: tb/tb_alien_formation_mover.sv
// Self-checking bench for alien_formation_mover (default or ALIEN_SPEEDUP_EN build).
module tb_alien_formation_mover;

    localparam int X_INIT = 64;
    localparam int Y_INIT = 48;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [1:0] Motion = 2'd0;
    logic [7:0] alive_cols = 8'hFF;

    logic       move_enable, canLeft, canRight, reached_bottom;
    logic [9:0] form_x;
    logic [8:0] form_y;

    always #5 clk = ~clk;

    alien_formation_mover #(
`ifdef ALIEN_SPEEDUP_EN
        .MIN_PERIOD  (4),
        .PERIOD_STEP (2)
`else
        .BASE_PERIOD (10)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .Motion         (Motion),
        .alive_cols     (alive_cols),
        .move_enable    (move_enable),
        .canLeft        (canLeft),
        .canRight       (canRight),
        .form_x         (form_x),
        .form_y         (form_y),
        .reached_bottom (reached_bottom)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int x;
        int y;
        bit cl;
        bit cr;
        bit rb;
        bit me;
        int since_tick;
    } mstate_t;

    mstate_t m;

    function automatic int exp_period(bit [7:0] al);
`ifdef ALIEN_SPEEDUP_EN
        return 4 + $countones(al) * 2;
`else
        return 10 + 0 * int'(al[0]);
`endif
    endfunction

    function automatic mstate_t model_next(mstate_t s, bit rst, bit rn, bit [1:0] mo, bit [7:0] al);
        mstate_t n;
        int lo, hi;
        bit any;
        n = s;
        lo = -1;
        hi = -1;
        any = (al != 0);
        if (rst) begin
            n.x = X_INIT; n.y = Y_INIT; n.cl = 0; n.cr = 0;
            n.rb = 0; n.me = 0; n.since_tick = 0;
            return n;
        end
        for (int c = 0; c < 8; c++) begin
            if (al[c]) begin
                if (lo < 0) lo = c;
                hi = c;
            end
        end
        // periodic tick: fires once the elapsed active cycles reach the period
        n.me = 0;
        if (rn && any && !s.rb) begin
            n.since_tick = s.since_tick + 1;
            if (n.since_tick >= exp_period(al)) begin
                n.me = 1;
                n.since_tick = 0;
            end
        end
        // can a step still keep the live edges on screen
        n.cl = any && (s.x + lo * 32 - 4 >= 8);
        n.cr = any && (s.x + hi * 32 + 24 + 4 <= 632);
        if (any && !s.rb) begin
            if (mo == 2'd1 && s.cl && s.x - 4 >= 0) n.x = s.x - 4;
            if (mo == 2'd2 && s.cr) n.x = s.x + 4;
            if (mo == 2'd3) begin
                n.y = s.y + 8;
                if (n.y + 3 * 24 + 24 >= 440) n.rb = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset, run, Motion, alive_cols);

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; Motion = 2'd0; alive_cols = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_motion(input logic [1:0] mo);
        Motion = mo;
        @(negedge clk);
        Motion = 2'd0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({move_enable, canLeft, canRight, reached_bottom, form_x, form_y} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 10'd64, 9'd48}) begin
            n_fail++;
            $display("FAIL reset_values: got me=%0b cl=%0b cr=%0b rb=%0b x=%0d y=%0d, want 0 0 0 0 64 48",
                     move_enable, canLeft, canRight, reached_bottom, form_x, form_y);
        end
    endtask

    task automatic test_tick();
        int p;
        do_reset();
        run = 1'b1;
        p = exp_period(8'hFF);
        for (int k = 1; k <= 3 * p; k++) begin
            @(negedge clk);
            n_checks++;
            if (move_enable !== ((k % p) == 0)) begin
                n_fail++;
                $display("FAIL tick_cycle_%0d: got %0b, want %0b", k, move_enable, (k % p) == 0);
            end
        end
        n_checks++;
        if ({canLeft, canRight} !== 2'b11) begin
            n_fail++;
            $display("FAIL tick_bounds: got cl=%0b cr=%0b, want 1 1", canLeft, canRight);
        end
    endtask

    task automatic test_right_edge();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 80; i++) pulse_motion(2'd2);
        n_checks++;
        if (form_x !== 10'd384 || canRight !== 1'b0) begin
            n_fail++;
            $display("FAIL right_80: got x=%0d cr=%0b, want x=384 cr=0", form_x, canRight);
        end
        pulse_motion(2'd2);
        n_checks++;
        if (form_x !== 10'd384) begin
            n_fail++;
            $display("FAIL right_81_held: got x=%0d, want 384", form_x);
        end
    endtask

    task automatic test_partial_cols();
        alive_cols = 8'b0111_1110;
        @(negedge clk);
        n_checks++;
        if ({canLeft, canRight} !== 2'b11) begin
            n_fail++;
            $display("FAIL partial_cols_bounds: got cl=%0b cr=%0b, want 1 1", canLeft, canRight);
        end
        alive_cols = 8'h00;
        run = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({canLeft, canRight} !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_bounds: got cl=%0b cr=%0b, want 0 0", canLeft, canRight);
        end
        pulse_motion(2'd1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (move_enable !== 1'b0 || form_x !== 10'd384) begin
                n_fail++;
                $display("FAIL empty_frozen: got me=%0b x=%0d, want me=0 x=384", move_enable, form_x);
            end
        end
    endtask

    task automatic test_bottom();
        int exp_y;
        bit exp_rb;
        do_reset();
        @(negedge clk);
        for (int k = 1; k <= 37; k++) begin
            pulse_motion(2'd3);
            exp_y  = Y_INIT + 8 * k;
            exp_rb = (exp_y + 96 >= 440);
            n_checks++;
            if (form_y !== 9'(exp_y) || reached_bottom !== exp_rb) begin
                n_fail++;
                $display("FAIL down_%0d: got y=%0d rb=%0b, want y=%0d rb=%0b",
                         k, form_y, reached_bottom, exp_y, exp_rb);
            end
        end
        pulse_motion(2'd1);
        pulse_motion(2'd3);
        n_checks++;
        if (form_x !== 10'd64 || form_y !== 9'd344 || reached_bottom !== 1'b1) begin
            n_fail++;
            $display("FAIL bottom_frozen: got x=%0d y=%0d rb=%0b, want 64 344 1",
                     form_x, form_y, reached_bottom);
        end
        run = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (move_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL bottom_no_tick: got me=%0b, want 0", move_enable);
            end
        end
    endtask

`ifdef ALIEN_SPEEDUP_EN
    task automatic test_speedup();
        do_reset();
        run = 1'b1;
        repeat (15) @(negedge clk);
        alive_cols = 8'b0000_0011;
        @(negedge clk);
        n_checks++;
        if (move_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL speedup_immediate: got %0b, want 1", move_enable);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (move_enable !== (k == 8)) begin
                n_fail++;
                $display("FAIL speedup_period8_cycle_%0d: got %0b, want %0b", k, move_enable, k == 8);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        pulse_motion(2'd2);
        pulse_motion(2'd3);
        reset  = 1'b1;
        Motion = 2'd1;
        @(negedge clk);
        n_checks++;
        if ({move_enable, canLeft, canRight, reached_bottom, form_x, form_y} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 10'd64, 9'd48}) begin
            n_fail++;
            $display("FAIL reset_mid: got me=%0b cl=%0b cr=%0b rb=%0b x=%0d y=%0d, want 0 0 0 0 64 48",
                     move_enable, canLeft, canRight, reached_bottom, form_x, form_y);
        end
        reset  = 1'b0;
        Motion = 2'd0;
    endtask

    task automatic test_random();
        logic [22:0] got, exp;
        int r, col;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 600; cyc++) begin
                run = ($urandom_range(0, 9) != 0);
                r = $urandom_range(0, 59);
                if (r < 10)      Motion = 2'd1;
                else if (r < 20) Motion = 2'd2;
                else if (r < 22) Motion = 2'd3;
                else             Motion = 2'd0;
                if ($urandom_range(0, 79) == 0) begin
                    col = $urandom_range(0, 7);
                    alive_cols[col] = 1'b0;
                end
                @(negedge clk);
                got = {move_enable, canLeft, canRight, reached_bottom, form_x, form_y};
                exp = {m.me, m.cl, m.cr, m.rb, 10'(m.x), 9'(m.y)};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random_ep%0d_cyc%0d: got me=%0b cl=%0b cr=%0b rb=%0b x=%0d y=%0d, want me=%0b cl=%0b cr=%0b rb=%0b x=%0d y=%0d",
                             ep, cyc, move_enable, canLeft, canRight, reached_bottom, form_x, form_y,
                             m.me, m.cl, m.cr, m.rb, m.x, m.y);
                end
            end
            Motion = 2'd0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tick();
        test_right_edge();
        test_partial_cols();
        test_bottom();
`ifdef ALIEN_SPEEDUP_EN
        test_speedup();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
